// File: rtl/ws2812_rx.sv
// WS2812 serial pixel receiver: decodes a one-wire GRB stream
// into indexed pixel strobes, with frame-end and protocol-error pulses.
module ws2812_rx #(
  parameter int SYSTEM_CLOCK = 48000000,
  parameter int NUM_LEDS = 8,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int CW = $clog2(NUM_LEDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          DI,
  output logic [AW-1:0] address,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          pixel_valid,
  output logic          frame_done,
  output logic [CW-1:0] pixel_count,
  output logic          error
);

  localparam int THRESH = SYSTEM_CLOCK * 3 / 5000000;
  localparam int RESET_CYCLES = SYSTEM_CLOCK / 20000;
  localparam int MAX_HIGH = SYSTEM_CLOCK / 500000;
  localparam int DW = $clog2(RESET_CYCLES + 2);

  localparam logic [DW-1:0] TH_LIM = DW'(THRESH);
  localparam logic [DW-1:0] RST_LIM = DW'(RESET_CYCLES);
  localparam logic [DW-1:0] HI_LIM = DW'(MAX_HIGH);
  localparam logic [CW-1:0] NL = CW'(NUM_LEDS);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] READY = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;

  logic          s1;
  logic          sdi;
  logic          sdi_d;
  logic          rise;
  logic          fall;
  logic          tog;
  logic [DW-1:0] cnt;
  logic [DW-1:0] run;
  logic          bit_val;
  logic          hi_long;
  logic          low_done;
  logic [1:0]    state;
  logic [4:0]    nbit;
  logic [22:0]   shreg;
  logic [23:0]   word;
  logic [CW-1:0] pidx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      sdi   <= 1'b0;
      sdi_d <= 1'b0;
    end else begin
      s1    <= DI;
      sdi   <= s1;
      sdi_d <= sdi;
    end
  end

  assign rise = sdi & ~sdi_d;
  assign fall = ~sdi & sdi_d;
  assign tog  = rise | fall;

  // cnt = cycles the previous level was held, seen on the edge cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tog) begin
      cnt <= DW'(1);
    end else if (cnt != RST_LIM) begin
      cnt <= cnt + DW'(1);
    end
  end

  assign run      = cnt + DW'(1);
  assign bit_val  = (cnt >= TH_LIM);
  assign hi_long  = (run >= HI_LIM);
  assign low_done = (run >= RST_LIM);
  assign word     = {shreg, bit_val};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      nbit        <= '0;
      shreg       <= '0;
      pidx        <= '0;
      address     <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      unique case (state)
        SYNC: begin
          if (!sdi && !tog && low_done) begin
            state <= READY;
          end
        end
        READY: begin
          if (rise) begin
            state <= HIGH;
            nbit  <= '0;
            shreg <= '0;
            pidx  <= '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            shreg <= word[22:0];
            if (nbit == 5'd23) begin
              nbit <= '0;
              if (pidx < NL) begin
                green_out   <= word[23:16];
                red_out     <= word[15:8];
                blue_out    <= word[7:0];
                address     <= pidx[AW-1:0];
                pixel_valid <= 1'b1;
                pidx        <= pidx + CW'(1);
              end
            end else begin
              nbit <= nbit + 5'd1;
            end
          end else if (hi_long) begin
            error <= 1'b1;
            state <= SYNC;
            nbit  <= '0;
            shreg <= '0;
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (low_done) begin
            frame_done  <= 1'b1;
            pixel_count <= pidx;
            state       <= READY;
            nbit        <= '0;
            shreg       <= '0;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: random bit timings scored against a
// frame-level model of the WS2812 decoding rules.
module tb_ws2812_rx;

  localparam int SYSTEM_CLOCK = 48000000;
  localparam int NUM_LEDS = 8;
  localparam int THRESH = SYSTEM_CLOCK * 3 / 5000000;
  localparam int RESET_CYC = SYSTEM_CLOCK / 20000;
  localparam int MAX_HIGH = SYSTEM_CLOCK / 500000;

  logic       clk = 1'b0;
  logic       reset;
  logic       DI;
  logic [2:0] address;
  logic [7:0] red_out;
  logic [7:0] green_out;
  logic [7:0] blue_out;
  logic       pixel_valid;
  logic       frame_done;
  logic [3:0] pixel_count;
  logic       error;

  ws2812_rx #(
    .SYSTEM_CLOCK(SYSTEM_CLOCK),
    .NUM_LEDS(NUM_LEDS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .DI(DI),
    .address(address),
    .red_out(red_out),
    .green_out(green_out),
    .blue_out(blue_out),
    .pixel_valid(pixel_valid),
    .frame_done(frame_done),
    .pixel_count(pixel_count),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fall = 0;

  int hs_q[$];
  int ls_q[$];
  logic [31:0] exp_pix[$];
  int exp_done[$];
  int exp_err;

  logic [31:0] got_pix[$];
  int got_done[$];
  int got_lat[$];
  int n_err = 0;
  int n_excl = 0;
  int p0, d0, l0, e0, x0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (pixel_valid) begin
        got_pix.push_back({8'(address), green_out, red_out, blue_out});
        got_lat.push_back(cyc - last_fall);
      end
      if (frame_done) got_done.push_back(int'(pixel_count));
      if (error) n_err++;
      if ((pixel_valid && frame_done) || (error && (pixel_valid || frame_done)))
        n_excl++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic seg(input int h, input int l);
    hs_q.push_back(h);
    ls_q.push_back(l);
  endtask

  task automatic rbits(input int n);
    bit b;
    repeat (n) begin
      b = 1'($urandom_range(0, 1));
      seg(b ? $urandom_range(THRESH, 50) : $urandom_range(8, THRESH - 1),
          $urandom_range(8, 30));
    end
  endtask

  // Reference: bits decoded by high time, frames split by long lows
  task automatic model(input bit synced0);
    bit sy, got;
    int nb, acc;
    logic [23:0] w;
    sy = synced0;
    got = 1'b0;
    nb = 0;
    acc = 0;
    w = '0;
    exp_pix.delete();
    exp_done.delete();
    exp_err = 0;
    foreach (hs_q[i]) begin
      if (hs_q[i] >= MAX_HIGH) begin
        if (sy) exp_err++;
        sy = 1'b0;
        got = 1'b0;
        nb = 0;
        acc = 0;
      end else if (hs_q[i] > 0 && sy) begin
        w = {w[22:0], hs_q[i] >= THRESH};
        nb++;
        got = 1'b1;
        if (nb == 24) begin
          nb = 0;
          if (acc < NUM_LEDS) begin
            exp_pix.push_back({8'(acc), w});
            acc++;
          end
        end
      end
      if (ls_q[i] >= RESET_CYC) begin
        if (sy && got) exp_done.push_back(acc);
        sy = 1'b1;
        got = 1'b0;
        nb = 0;
        acc = 0;
      end
    end
  endtask

  task automatic drive();
    foreach (hs_q[i]) begin
      if (hs_q[i] > 0) begin
        DI = 1'b1;
        repeat (hs_q[i]) begin
          @(posedge clk);
          #2;
        end
        DI = 1'b0;
        last_fall = cyc;
      end
      repeat (ls_q[i]) begin
        @(posedge clk);
        #2;
      end
    end
    hs_q.delete();
    ls_q.delete();
  endtask

  task automatic snap();
    p0 = got_pix.size();
    d0 = got_done.size();
    l0 = got_lat.size();
    e0 = n_err;
    x0 = n_excl;
  endtask

  task automatic compare(input string tag);
    repeat (10) @(posedge clk);
    #2;
    check({tag, " npix"}, got_pix.size() - p0, exp_pix.size());
    foreach (exp_pix[k])
      if (p0 + k < got_pix.size())
        check({tag, " pix"}, got_pix[p0 + k], exp_pix[k]);
    check({tag, " ndone"}, got_done.size() - d0, exp_done.size());
    foreach (exp_done[k])
      if (d0 + k < got_done.size())
        check({tag, " count"}, got_done[d0 + k], exp_done[k]);
    check({tag, " err"}, n_err - e0, exp_err);
    for (int k = l0; k < got_lat.size(); k++)
      check({tag, " lat"}, got_lat[k], 3);
    check({tag, " excl"}, n_excl - x0, 0);
  endtask

  task automatic run(input string tag, input bit synced0);
    model(synced0);
    snap();
    drive();
    compare(tag);
  endtask

  initial begin
    logic [23:0] w;
    reset = 1'b0;
    DI = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("reset outs", {address, red_out, green_out, blue_out, pixel_valid,
                         frame_done, pixel_count, error}, 0);
    reset = 1'b1;

    seg(0, RESET_CYC);
    w = 24'h123456;
    for (int b = 23; b >= 0; b--) seg(w[b] ? 38 : 19, w[b] ? 22 : 41);
    seg(0, RESET_CYC);
    run("one pixel", 1'b0);
    check("one red", red_out, 8'h34);
    check("one green", green_out, 8'h12);
    check("one blue", blue_out, 8'h56);
    check("one addr", address, 0);
    check("one count", pixel_count, 1);

    seg(0, RESET_CYC);
    rbits(240);
    seg(0, RESET_CYC);
    run("ten pixels", 1'b1);
    check("ten hold", {8'(address), green_out, red_out, blue_out},
          exp_pix[exp_pix.size() - 1]);
    check("ten count", pixel_count, NUM_LEDS);

    seg(0, RESET_CYC);
    seg(27, 30);
    seg(28, 30);
    rbits(9);
    seg(40, RESET_CYC - 1);
    rbits(12);
    seg(0, RESET_CYC);
    run("low 2399", 1'b1);
    check("thresh bits", green_out[7:6], 2'b01);

    seg(0, RESET_CYC);
    rbits(11);
    seg(40, RESET_CYC);
    rbits(12);
    seg(0, RESET_CYC);
    run("low 2400", 1'b1);

    seg(0, RESET_CYC);
    rbits(10);
    seg(MAX_HIGH, 100);
    rbits(30);
    seg(0, RESET_CYC);
    rbits(24);
    seg(0, RESET_CYC);
    run("long high", 1'b1);

    seg(0, RESET_CYC);
    rbits(12);
    snap();
    drive();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midreset outs", {address, red_out, green_out, blue_out, pixel_valid,
                            frame_done, pixel_count, error}, 0);
    check("midreset npix", got_pix.size() - p0, 0);
    check("midreset ndone", got_done.size() - d0, 0);
    reset = 1'b1;
    rbits(48);
    seg(0, RESET_CYC);
    run("post reset", 1'b0);

    seg(0, RESET_CYC);
    seg(MAX_HIGH - 1, 30);
    rbits(33);
    seg(0, RESET_CYC);
    run("partial", 1'b1);

    for (int f = 0; f < 2; f++) begin
      seg(0, RESET_CYC);
      rbits(24 * $urandom_range(1, 3) + $urandom_range(0, 23));
      seg(0, RESET_CYC);
      run("random", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
